// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types, constants and helpers for the capture/dump controller
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAP_PRE,
    CAP_ARM,
    CAP_POST,
    DUMP_RD,
    DUMP_VLD
  } cap_state_t;

  localparam logic [1:0] TRIG_OFF  = 2'b00;
  localparam logic [1:0] TRIG_NORM = 2'b01;
  localparam logic [1:0] TRIG_AUTO = 2'b10;

  // largest decimation exponent the decimator counter can express
  localparam int MAX_DEC_PWR = 15;

  // a zero post-trigger count still keeps the trigger sample itself
  function automatic logic [31:0] clamp_trig_pos(input logic [31:0] tp);
    return (tp == 32'd0) ? 32'd1 : tp;
  endfunction

endpackage

// File: rtl/cap_decimator.sv
// rtl/cap_decimator.sv - sample-strobe decimator producing the kept-sample qualifier
module cap_decimator
  import capture_pkg::*;
#(
  parameter int DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_en,
  input  logic [DEC_W-1:0] dec_pwr,
  input  logic             clr,
  output logic             keep
);

  logic [MAX_DEC_PWR-1:0] cnt;
  logic [MAX_DEC_PWR-1:0] lim;
  logic [31:0]            pwr_ext;

  // terminal count is 2**dec_pwr - 1, with the exponent clamped to what the counter holds
  always_comb begin
    pwr_ext = 32'(dec_pwr);
    if (pwr_ext > 32'(MAX_DEC_PWR)) begin
      pwr_ext = 32'(MAX_DEC_PWR);
    end
    lim = MAX_DEC_PWR'((32'd1 << pwr_ext) - 32'd1);
  end

  assign keep = smpl_en && (cnt == lim);

  // strobe counter: restarts on capture entry and after every kept sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (smpl_en) begin
      cnt <= keep ? '0 : cnt + MAX_DEC_PWR'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - circular-buffer capture and chronological dump controller for trace RAMs
module capture_ctrl
  import capture_pkg::*;
#(
  parameter  int ADDR_W = 9,
  parameter  int DEC_W  = 4,
  parameter  int NUM_CH = 3,
  localparam int CH_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_en,
  input  logic              trigger,
  input  logic [1:0]        trig_type,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  dec_pwr,
  input  logic              capture_done,
  input  logic              abort,
  input  logic              start_dump,
  input  logic [CH_W-1:0]   dump_ch,
  input  logic              dump_rdy,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [CH_W-1:0]   ch_sel,
  output logic [ADDR_W-1:0] trace_end,
  output logic              armed,
  output logic              set_capture_done,
  output logic              dump_vld,
  output logic              dump_finished
);

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, pre_cnt, post_cnt, tp_eff;
  logic [1:0]        trig_type_q;
  logic [DEC_W-1:0]  dec_pwr_q;
  logic              keep, in_cap, in_dump, wr, fire, post_dec;
  logic              pre_done, post_done, cap_start, dump_start, hs, last_hs;

  cap_decimator #(.DEC_W(DEC_W)) u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .smpl_en (smpl_en),
    .dec_pwr (dec_pwr_q),
    .clr     (cap_start),
    .keep    (keep)
  );

  // event decode shared by the FSM, outputs and datapath; abort masks every event
  always_comb begin
    tp_eff     = ADDR_W'(clamp_trig_pos(32'(trig_pos)));
    in_cap     = (state == CAP_PRE) || (state == CAP_ARM) || (state == CAP_POST);
    in_dump    = (state == DUMP_RD) || (state == DUMP_VLD);
    wr         = in_cap && keep && !abort;
    dump_start = (state == IDLE) && !abort && start_dump;
    cap_start  = (state == IDLE) && !abort && !start_dump && !capture_done
                 && (trig_type != TRIG_OFF);
    fire       = (state == CAP_ARM) && wr
                 && (((trig_type_q == TRIG_NORM) && trigger) || ((trig_type_q & TRIG_AUTO) != 2'b00));
    post_dec   = fire || ((state == CAP_POST) && wr);
    post_done  = post_dec && (post_cnt == ADDR_W'(1));
    pre_done   = (state == CAP_PRE) && wr && (pre_cnt == ADDR_W'(1));
    hs         = (state == DUMP_VLD) && dump_rdy && !abort;
    last_hs    = hs && (rd_ptr == trace_end);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; a single-sample post window completes on the trigger write itself
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start)     state_nxt = DUMP_RD;
          else if (cap_start) state_nxt = CAP_PRE;
        end
        CAP_PRE:  if (pre_done) state_nxt = CAP_ARM;
        CAP_ARM: begin
          if (post_done) state_nxt = IDLE;
          else if (fire) state_nxt = CAP_POST;
        end
        CAP_POST: if (post_done) state_nxt = IDLE;
        DUMP_RD:  state_nxt = DUMP_VLD;
        DUMP_VLD: begin
          if (last_hs) state_nxt = IDLE;
          else if (hs) state_nxt = DUMP_RD;
        end
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // RAM strobes and handshake outputs, all combinational so writes land in the strobe cycle
  always_comb begin
    en               = wr || in_dump;
    we               = wr;
    addr             = in_dump ? rd_ptr : wr_ptr;
    dump_vld         = (state == DUMP_VLD);
    set_capture_done = post_done;
    dump_finished    = last_hs;
  end

  // capture datapath: write pointer, newest-sample address and pre/post counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      trace_end   <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trig_type_q <= '0;
      dec_pwr_q   <= '0;
    end else begin
      if (wr) begin
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        trace_end <= wr_ptr;
      end
      if ((state == CAP_PRE) && wr) begin
        pre_cnt <= pre_cnt - ADDR_W'(1);
      end
      if (post_dec) begin
        post_cnt <= post_cnt - ADDR_W'(1);
      end
      if (cap_start) begin
        pre_cnt     <= '0 - tp_eff;
        post_cnt    <= tp_eff;
        trig_type_q <= trig_type;
        dec_pwr_q   <= dec_pwr;
      end
    end
  end

  // dump datapath: read pointer starts just past the newest sample so data comes out oldest first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      ch_sel <= '0;
    end else begin
      if (dump_start) begin
        rd_ptr <= trace_end + ADDR_W'(1);
        ch_sel <= (32'(dump_ch) >= 32'(NUM_CH)) ? '0 : dump_ch;
      end
      if (hs && !last_hs) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // armed flag: set by the last pre-trigger write, held through the post window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (abort || post_done) begin
      armed <= 1'b0;
    end else if (pre_done) begin
      armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for the capture/dump controller
module tb_capture_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEC_W  = 4;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              smpl_en, trigger, capture_done, abort, start_dump, dump_rdy;
  logic [1:0]        trig_type;
  logic [ADDR_W-1:0] trig_pos;
  logic [DEC_W-1:0]  dec_pwr;
  logic [CH_W-1:0]   dump_ch;
  logic              en, we, armed, set_capture_done, dump_vld, dump_finished;
  logic [ADDR_W-1:0] addr, trace_end;
  logic [CH_W-1:0]   ch_sel;

  capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W), .NUM_CH(NUM_CH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .smpl_en          (smpl_en),
    .trigger          (trigger),
    .trig_type        (trig_type),
    .trig_pos         (trig_pos),
    .dec_pwr          (dec_pwr),
    .capture_done     (capture_done),
    .abort            (abort),
    .start_dump       (start_dump),
    .dump_ch          (dump_ch),
    .dump_rdy         (dump_rdy),
    .en               (en),
    .we               (we),
    .addr             (addr),
    .ch_sel           (ch_sel),
    .trace_end        (trace_end),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .dump_vld         (dump_vld),
    .dump_finished    (dump_finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              is_dump;
    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   ch;
    logic              flag;
  } ev_t;

  ev_t               exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                n_scd = 0;
  logic [ADDR_W-1:0] wp = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_writes(input int n, input bit scd_last);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{is_dump: 1'b0, addr: wp, ch: '0, flag: (scd_last && (i == n - 1))});
      wp = wp + ADDR_W'(1);
    end
  endtask

  task automatic push_dumps(input int n, input logic [ADDR_W-1:0] a0, input logic [CH_W-1:0] ch, input bit fin_last);
    logic [ADDR_W-1:0] a;
    a = a0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{is_dump: 1'b1, addr: a, ch: ch, flag: (fin_last && (i == n - 1))});
      a = a + ADDR_W'(1);
    end
  endtask

  task automatic start_cap(input logic [1:0] tt, input logic [ADDR_W-1:0] tp, input logic [DEC_W-1:0] dp);
    trig_type    = tt;
    trig_pos     = tp;
    dec_pwr      = dp;
    capture_done = 1'b0;
    tick();
    trig_type    = 2'b00;
  endtask

  task automatic strobes(input int n);
    smpl_en = 1'b1;
    repeat (n) tick();
    smpl_en = 1'b0;
  endtask

  // monitor: every RAM write or dump handshake is matched against the scoreboard
  always @(negedge clk) begin
    ev_t got;
    if (rst_n) begin
      if ((en && we) || (dump_vld && dump_rdy)) begin
        got.is_dump = dump_vld && dump_rdy;
        got.addr    = addr;
        got.ch      = got.is_dump ? ch_sel : '0;
        got.flag    = got.is_dump ? dump_finished : set_capture_done;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got 0x%0h, none required", got);
        end else begin
          check("ram_event", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (set_capture_done) n_scd++;
      if (set_capture_done && !(en && we)) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_capture_done: got pulse without a write, required none");
      end
      if (dump_finished && !(dump_vld && dump_rdy)) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_dump_finished: got pulse without a handshake, required none");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; smpl_en = 1'b0; trigger = 1'b0; trig_type = 2'b00; trig_pos = '0;
    dec_pwr = '0; capture_done = 1'b0; abort = 1'b0; start_dump = 1'b0; dump_ch = '0; dump_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({en, we, addr, ch_sel, trace_end, armed, set_capture_done, dump_vld, dump_finished}), 32'd0);
    rst_n = 1'b1;
    tick();

    // capture: 412 pre writes, trigger, 100 post writes
    push_writes(412, 1'b0);
    start_cap(2'b01, 9'd100, 4'd0);
    smpl_en = 1'b1;
    repeat (411) tick();
    check("armed_before_last_pre", 32'(armed), 32'd0);
    tick();
    smpl_en = 1'b0;
    check("armed_after_pre", 32'(armed), 32'd1);
    push_writes(100, 1'b1);
    smpl_en = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (99) tick();
    smpl_en = 1'b0;
    check("cap1_armed_clear", 32'(armed), 32'd0);
    check("cap1_trace_end", 32'(trace_end), 32'd511);
    check("cap1_scd_count", 32'(n_scd), 32'd1);
    check("cap1_drained", 32'(exp_q.size()), 32'd0);

    // full dump of channel 2 with random back-pressure
    push_dumps(DEPTH, 9'd0, 2'd2, 1'b1);
    capture_done = 1'b1; dump_ch = 2'd2; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    check("dump_rd_strobes", 32'({dump_vld, en, we, addr, ch_sel}), 32'({1'b0, 1'b1, 1'b0, 9'd0, 2'd2}));
    tick();
    check("dump_vld_latency", 32'(dump_vld), 32'd1);
    for (int c = 0; c < 6000 && exp_q.size() > 0; c++) begin
      dump_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    dump_rdy = 1'b0;
    check("dump_drained", 32'(exp_q.size()), 32'd0);
    check("dump_idle_after", 32'(dump_vld), 32'd0);

    // decimation by 8: writes only on strobes 8, 16, 24
    push_writes(3, 1'b0);
    start_cap(2'b01, 9'd100, 4'd3);
    for (int k = 1; k <= 24; k++) begin
      smpl_en = 1'b1;
      #1;
      check("dec_write", 32'(en && we), 32'((k % 8) == 0));
      tick();
      smpl_en = 1'b0;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("dec_drained", 32'(exp_q.size()), 32'd0);

    // autoroll with trigger held low, post window of 3
    push_writes(509, 1'b0);
    start_cap(2'b10, 9'd3, 4'd0);
    strobes(509);
    check("auto_armed", 32'(armed), 32'd1);
    repeat (3) tick();
    push_writes(3, 1'b1);
    strobes(3);
    check("auto_armed_clear", 32'(armed), 32'd0);
    check("auto_trace_end", 32'(trace_end), 32'd2);
    check("auto_scd_count", 32'(n_scd), 32'd2);

    // trig_pos 0 behaves as 1: the trigger write alone completes the capture
    push_writes(511, 1'b0);
    start_cap(2'b01, 9'd0, 4'd0);
    strobes(511);
    check("tp0_armed", 32'(armed), 32'd1);
    push_writes(1, 1'b1);
    smpl_en = 1'b1; trigger = 1'b1;
    tick();
    smpl_en = 1'b0; trigger = 1'b0;
    check("tp0_armed_clear", 32'(armed), 32'd0);
    check("tp0_scd_count", 32'(n_scd), 32'd3);
    check("tp0_drained", 32'(exp_q.size()), 32'd0);

    // capture_done blocks capture; start_dump wins as capture_done falls
    capture_done = 1'b1; trig_type = 2'b01; trig_pos = 9'd50; smpl_en = 1'b1;
    repeat (5) tick();
    check("blocked_no_write", 32'({en, armed}), 32'd0);
    smpl_en = 1'b0;
    capture_done = 1'b0; start_dump = 1'b1; dump_ch = 2'd1;
    tick();
    start_dump = 1'b0; trig_type = 2'b00; capture_done = 1'b1;
    check("dump_wins", 32'({dump_vld, en, we, addr, ch_sel}), 32'({1'b0, 1'b1, 1'b0, 9'd3, 2'd1}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("dump_abort_idle", 32'({en, dump_vld}), 32'd0);

    // abort in the middle of the post window
    push_writes(502, 1'b0);
    start_cap(2'b01, 9'd10, 4'd0);
    strobes(502);
    push_writes(5, 1'b0);
    smpl_en = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    #1;
    check("abort_masks_write", 32'({en, armed}), 32'({1'b0, 1'b1}));
    tick();
    abort = 1'b0;
    check("abort_armed_clear", 32'(armed), 32'd0);
    check("abort_trace_end", 32'(trace_end), 32'd509);
    check("abort_scd_count", 32'(n_scd), 32'd3);
    tick();
    smpl_en = 1'b0;
    check("abort_idle", 32'(en), 32'd0);

    // out-of-range channel maps to 0; reset in the middle of a dump
    push_dumps(4, 9'd510, 2'd0, 1'b0);
    dump_ch = 2'd3; start_dump = 1'b1;
    tick();
    start_dump = 1'b0; dump_rdy = 1'b1;
    repeat (8) tick();
    dump_rdy = 1'b0;
    tick();
    check("pre_reset_vld", 32'({dump_vld, ch_sel}), 32'({1'b1, 2'd0}));
    rst_n = 1'b0;
    #1;
    check("reset_mid_dump", 32'({dump_vld, en, trace_end, armed}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
